reg_shift_bank: RTL and testbench
=================================

Name: reg_shift_bank

Overview:
Parametrised bank of DEPTH registers, each SIZE bits wide, with synchronous clear, serial shift-in and indexed parallel load. Each entry carries its own valid bit, and the block reports the number of valid entries and a full flag. It replaces chains of single load/clear registers in the CNN datapath, for example as a convolution window row buffer or a kernel-weight holder. Downstream logic reads all entries in parallel.

Parameters:
SIZE, 8, bit width of each entry (>=1)
DEPTH, 5, number of entries (>=2)
IDX_W, $clog2(DEPTH), localparam; width of ldIdx
CNT_W, $clog2(DEPTH+1), localparam; width of count

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low (0 = reset)
clr  input  1  synchronous clear of all entries and valid bits
shEn  input  1  shift: entry0 <= dataIn, entry[i] <= entry[i-1]
ld  input  1  indexed load of dataIn into entry[ldIdx]
ldIdx  input  IDX_W  target entry for ld
dataIn  input  SIZE  write data for shift or load
dataOut  output  DEPTH*SIZE  all entries flattened; entry i at bits [i*SIZE +: SIZE]
tailOut  output  SIZE  entry[DEPTH-1], combinational from register
validVec  output  DEPTH  per-entry valid bits
count  output  CNT_W  popcount of validVec, registered
full  output  1  1 when all DEPTH valid bits are set, registered
dropPulse  output  1  one-cycle pulse, cycle after a shift discarded a valid tail entry

Behaviour:
- All state updates on posedge clk only. rst is sampled at the edge and has no asynchronous path.
- Priority per edge: rst==0 > clr > shEn > ld > hold.
- Reset (rst==0): all entries = 0, validVec = 0, count = 0, full = 0, dataOut = 0, tailOut = 0, dropPulse = 0.
- clr (rst==1): same values as reset. Any shEn or ld in the same cycle is ignored.
- shEn:
  - entry0 <= dataIn, valid0 <= 1.
  - entry[i] <= entry[i-1] and valid[i] <= valid[i-1] for i = 1..DEPTH-1.
  - The old entry[DEPTH-1] is discarded. dropPulse = 1 on the next cycle only if the old valid[DEPTH-1] was 1; otherwise 0.
- ld with shEn==0:
  - If ldIdx < DEPTH: entry[ldIdx] <= dataIn, valid[ldIdx] <= 1. Other entries are unchanged.
  - If ldIdx >= DEPTH (possible when DEPTH is not a power of 2): no state change, and the request is silently dropped.
- shEn and ld asserted together: shift only; ld is ignored.
- Hold (no command): all state is retained.
- dropPulse is 0 in every cycle not directly following a dropping shift.
- count and full are registered alongside validVec, so they always agree with validVec in the same cycle; there is no extra latency.
  - count saturates naturally at DEPTH.
  - full = (count == DEPTH).
- Write latency is 1 cycle: data written at edge N is visible on dataOut after edge N.
- Reset mid-operation: state returns to the reset values at that edge regardless of any commands; no partial update occurs.
- Arithmetic: no arithmetic on data. Entries are stored unsigned and opaque, with no truncation or extension.

Decomposition:
- Shared package cnn_pkg holds the default SIZE and DEPTH constants for window and weight buffers, plus the command priority encoding (CMD_HOLD, CMD_LOAD, CMD_SHIFT, CMD_CLR) used as an internal enum.
- A single sub-module, reg_entry, is natural: one SIZE-bit register plus its valid bit, with clear, shift-select and load-enable inputs.
  - reg_shift_bank instantiates DEPTH copies in a generate loop.
  - It adds the command decode, the popcount/full logic and the dropPulse register.

Test Plan:
- Reset: with DEPTH=5, SIZE=8, hold rst=0 for 2 cycles while shEn=1 and dataIn=0xAA -> dataOut=0, validVec=0, count=0, full=0, dropPulse=0. Also confirm that a rst low pulse between edges has no effect.
- Shift fill: shift in 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles -> entry0..4 = 0x55, 0x44, 0x33, 0x22, 0x11, count=5, full=1, tailOut=0x11, dropPulse stays 0.
- Overflow: from the full state, shift in 0x66 -> entry0=0x66, tailOut=0x22, count=5, dropPulse=1 for exactly one cycle. On a bank holding only 3 valid entries, a shift gives dropPulse=0.
- Indexed load: after reset, ld with ldIdx=3 and dataIn=0x7E -> validVec=5'b01000, count=1. Then ld with ldIdx=6 -> no change. Then ld with ldIdx=3 and dataIn=0x01 -> entry3=0x01, count stays 1.
- Simultaneous commands:
  - shEn=1, ld=1, ldIdx=0, dataIn=0x9 -> shift result only.
  - clr=1, shEn=1 -> all entries 0, count=0.
  - rst=0, clr=0, ld=1 -> reset values.
- Parameter sweep: repeat the shift fill and overflow scenarios with DEPTH=2, SIZE=1 and with DEPTH=9, SIZE=16 -> count width and full threshold correct (2 and 9), with no X on any output.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN buffer geometry and the command priority encoding
package cnn_pkg;
  localparam int WIN_SIZE = 8;
  localparam int WIN_DEPTH = 5;
  localparam int WGT_SIZE = 8;
  localparam int WGT_DEPTH = 9;
  typedef enum logic [1:0] {CMD_HOLD, CMD_LOAD, CMD_SHIFT, CMD_CLR} cmd_e;
  function automatic cmd_e decode_cmd(input logic clr, input logic sh, input logic ld);
    return clr ? CMD_CLR : sh ? CMD_SHIFT : ld ? CMD_LOAD : CMD_HOLD;
  endfunction
endpackage

// File: rtl/reg_entry.sv
// reg_entry: one data register plus valid bit with clear, shift-select and load-enable
module reg_entry #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            sh_i,
  input  logic            ld_i,
  input  logic [SIZE-1:0] sh_data_i,
  input  logic            sh_valid_i,
  input  logic [SIZE-1:0] ld_data_i,
  output logic [SIZE-1:0] data_o,
  output logic            valid_o
);
  logic [SIZE-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  always_comb begin
    data_d = clr_i ? '0 : sh_i ? sh_data_i : ld_i ? ld_data_i : data_q;
    valid_d = clr_i ? 1'b0 : sh_i ? sh_valid_i : ld_i ? 1'b1 : valid_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  assign data_o = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/reg_shift_bank.sv
// reg_shift_bank: DEPTH x SIZE register bank with clear, serial shift-in and indexed load
module reg_shift_bank
  import cnn_pkg::*;
#(
  parameter int SIZE = WIN_SIZE,
  parameter int DEPTH = WIN_DEPTH,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shEn,
  input  logic                  ld,
  input  logic [IDX_W-1:0]      ldIdx,
  input  logic [SIZE-1:0]       dataIn,
  output logic [DEPTH*SIZE-1:0] dataOut,
  output logic [SIZE-1:0]       tailOut,
  output logic [DEPTH-1:0]      validVec,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  dropPulse
);
  cmd_e                  cmd;
  logic [DEPTH-1:0]      ld_hit, sh_valid, valid_d;
  logic [DEPTH*SIZE-1:0] sh_data;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, drop_q;
  // count/full are derived from the next valid vector so they land with it
  always_comb begin
    cmd = decode_cmd(clr, shEn, ld);
    for (int k = 0; k < DEPTH; k++) ld_hit[k] = (cmd == CMD_LOAD) && (ldIdx == IDX_W'(k));
    sh_data = {dataOut[(DEPTH-1)*SIZE-1:0], dataIn};
    sh_valid = {validVec[DEPTH-2:0], 1'b1};
    valid_d = cmd == CMD_CLR ? '0 : cmd == CMD_SHIFT ? sh_valid : validVec | ld_hit;
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) count_d = count_d + CNT_W'(valid_d[k]);
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    reg_entry #(.SIZE(SIZE)) u_ent (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (cmd == CMD_CLR),
      .sh_i       (cmd == CMD_SHIFT),
      .ld_i       (ld_hit[g]),
      .sh_data_i  (sh_data[g*SIZE +: SIZE]),
      .sh_valid_i (sh_valid[g]),
      .ld_data_i  (dataIn),
      .data_o     (dataOut[g*SIZE +: SIZE]),
      .valid_o    (validVec[g])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      full_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q <= count_d == CNT_W'(DEPTH);
      drop_q <= (cmd == CMD_SHIFT) && validVec[DEPTH-1];
    end
  end
  assign tailOut = dataOut[(DEPTH-1)*SIZE +: SIZE];
  assign count = count_q;
  assign full = full_q;
  assign dropPulse = drop_q;
endmodule

// File: tb/tb_reg_shift_bank.sv
// tb_reg_shift_bank: directed checks of reg_shift_bank at 5x8, 2x1 and 9x16
module tb_reg_shift_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int nchk = 0;
  int nerr = 0;

  logic rst = 1'b0, clr = 1'b0, shEn = 1'b0, ld = 1'b0;
  logic [2:0] ldIdx = '0;
  logic [7:0] dataIn = '0, tailOut;
  logic [39:0] dataOut;
  logic [4:0] validVec;
  logic [2:0] count;
  logic full, dropPulse;
  reg_shift_bank #(.SIZE(8), .DEPTH(5)) u0 (.clk(clk), .rst(rst), .clr(clr), .shEn(shEn), .ld(ld),
    .ldIdx(ldIdx), .dataIn(dataIn), .dataOut(dataOut), .tailOut(tailOut), .validVec(validVec),
    .count(count), .full(full), .dropPulse(dropPulse));

  logic rst1 = 1'b0, sh1 = 1'b0;
  logic [0:0] din1 = '0, tail1;
  logic [1:0] dout1, vv1, cnt1;
  logic full1, drop1;
  reg_shift_bank #(.SIZE(1), .DEPTH(2)) u1 (.clk(clk), .rst(rst1), .clr(1'b0), .shEn(sh1), .ld(1'b0),
    .ldIdx(1'b0), .dataIn(din1), .dataOut(dout1), .tailOut(tail1), .validVec(vv1),
    .count(cnt1), .full(full1), .dropPulse(drop1));

  logic rst2 = 1'b0, sh2 = 1'b0;
  logic [15:0] din2 = '0, tail2;
  logic [143:0] dout2;
  logic [8:0] vv2;
  logic [3:0] cnt2;
  logic full2, drop2;
  reg_shift_bank #(.SIZE(16), .DEPTH(9)) u2 (.clk(clk), .rst(rst2), .clr(1'b0), .shEn(sh2), .ld(1'b0),
    .ldIdx(4'd0), .dataIn(din2), .dataOut(dout2), .tailOut(tail2), .validVec(vv2),
    .count(cnt2), .full(full2), .dropPulse(drop2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; shEn = 1'b1; dataIn = 8'hAA;
    tick(); tick();
    nchk++; if (dataOut !== 40'h0) begin nerr++; $display("FAIL rst_data got %h exp %h", dataOut, 40'h0); end
    nchk++; if (validVec !== 5'b0) begin nerr++; $display("FAIL rst_valid got %b exp %b", validVec, 5'b0); end
    nchk++; if (count !== 3'd0) begin nerr++; $display("FAIL rst_count got %0d exp 0", count); end
    nchk++; if (full !== 1'b0) begin nerr++; $display("FAIL rst_full got %b exp 0", full); end
    nchk++; if (dropPulse !== 1'b0) begin nerr++; $display("FAIL rst_drop got %b exp 0", dropPulse); end
    rst = 1'b1; dataIn = 8'h5A;
    tick();
    shEn = 1'b0;
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    nchk++; if (dataOut !== 40'h5A) begin nerr++; $display("FAIL rst_glitch_data got %h exp %h", dataOut, 40'h5A); end
    nchk++; if (count !== 3'd1) begin nerr++; $display("FAIL rst_glitch_count got %0d exp 1", count); end
  endtask

  task automatic test_shift_fill();
    logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      shEn = 1'b1; dataIn = vals[i];
      tick();
      nchk++; if (dropPulse !== 1'b0) begin nerr++; $display("FAIL fill_drop%0d got %b exp 0", i, dropPulse); end
      nchk++; if (count !== 3'(i + 1)) begin nerr++; $display("FAIL fill_count%0d got %0d exp %0d", i, count, i + 1); end
    end
    shEn = 1'b0;
    nchk++; if (dataOut !== 40'h1122334455) begin nerr++; $display("FAIL fill_data got %h exp %h", dataOut, 40'h1122334455); end
    nchk++; if (tailOut !== 8'h11) begin nerr++; $display("FAIL fill_tail got %h exp 11", tailOut); end
    nchk++; if (full !== 1'b1) begin nerr++; $display("FAIL fill_full got %b exp 1", full); end
    nchk++; if (validVec !== 5'b11111) begin nerr++; $display("FAIL fill_valid got %b exp 11111", validVec); end
  endtask

  task automatic test_overflow();
    shEn = 1'b1; dataIn = 8'h66;
    tick();
    shEn = 1'b0;
    nchk++; if (dataOut !== 40'h2233445566) begin nerr++; $display("FAIL ovf_data got %h exp %h", dataOut, 40'h2233445566); end
    nchk++; if (tailOut !== 8'h22) begin nerr++; $display("FAIL ovf_tail got %h exp 22", tailOut); end
    nchk++; if (count !== 3'd5) begin nerr++; $display("FAIL ovf_count got %0d exp 5", count); end
    nchk++; if (dropPulse !== 1'b1) begin nerr++; $display("FAIL ovf_drop got %b exp 1", dropPulse); end
    tick();
    nchk++; if (dropPulse !== 1'b0) begin nerr++; $display("FAIL ovf_drop_end got %b exp 0", dropPulse); end
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      shEn = 1'b1; dataIn = 8'(i);
      tick();
      nchk++; if (dropPulse !== 1'b0) begin nerr++; $display("FAIL partial_drop%0d got %b exp 0", i, dropPulse); end
    end
    shEn = 1'b0;
    nchk++; if (count !== 3'd4) begin nerr++; $display("FAIL partial_count got %0d exp 4", count); end
  endtask

  task automatic test_indexed_load();
    clr = 1'b1; tick(); clr = 1'b0;
    ld = 1'b1; ldIdx = 3'd3; dataIn = 8'h7E;
    tick();
    nchk++; if (validVec !== 5'b01000) begin nerr++; $display("FAIL ld_valid got %b exp 01000", validVec); end
    nchk++; if (count !== 3'd1) begin nerr++; $display("FAIL ld_count got %0d exp 1", count); end
    nchk++; if (dataOut !== 40'h007E000000) begin nerr++; $display("FAIL ld_data got %h exp %h", dataOut, 40'h007E000000); end
    ldIdx = 3'd6; dataIn = 8'hFF;
    tick();
    nchk++; if (dataOut !== 40'h007E000000) begin nerr++; $display("FAIL ld_oob_data got %h exp %h", dataOut, 40'h007E000000); end
    nchk++; if (validVec !== 5'b01000) begin nerr++; $display("FAIL ld_oob_valid got %b exp 01000", validVec); end
    ldIdx = 3'd3; dataIn = 8'h01;
    tick();
    nchk++; if (dataOut !== 40'h0001000000) begin nerr++; $display("FAIL ld_over_data got %h exp %h", dataOut, 40'h0001000000); end
    nchk++; if (count !== 3'd1) begin nerr++; $display("FAIL ld_over_count got %0d exp 1", count); end
    ldIdx = 3'd4; dataIn = 8'hC3;
    tick();
    ld = 1'b0;
    nchk++; if (tailOut !== 8'hC3) begin nerr++; $display("FAIL ld_top_tail got %h exp c3", tailOut); end
    nchk++; if (count !== 3'd2) begin nerr++; $display("FAIL ld_top_count got %0d exp 2", count); end
    nchk++; if (full !== 1'b0) begin nerr++; $display("FAIL ld_top_full got %b exp 0", full); end
  endtask

  task automatic test_simultaneous();
    shEn = 1'b1; ld = 1'b1; ldIdx = 3'd0; dataIn = 8'h09;
    tick();
    nchk++; if (dataOut !== 40'h0100000009) begin nerr++; $display("FAIL shld_data got %h exp %h", dataOut, 40'h0100000009); end
    nchk++; if (validVec !== 5'b10001) begin nerr++; $display("FAIL shld_valid got %b exp 10001", validVec); end
    nchk++; if (dropPulse !== 1'b1) begin nerr++; $display("FAIL shld_drop got %b exp 1", dropPulse); end
    ld = 1'b0; clr = 1'b1; dataIn = 8'hFF;
    tick();
    nchk++; if (dataOut !== 40'h0) begin nerr++; $display("FAIL clrsh_data got %h exp 0", dataOut); end
    nchk++; if (count !== 3'd0) begin nerr++; $display("FAIL clrsh_count got %0d exp 0", count); end
    nchk++; if (dropPulse !== 1'b0) begin nerr++; $display("FAIL clrsh_drop got %b exp 0", dropPulse); end
    clr = 1'b0; dataIn = 8'hAB;
    tick();
    shEn = 1'b0; rst = 1'b0; ld = 1'b1; ldIdx = 3'd2; dataIn = 8'h77;
    tick();
    rst = 1'b1; ld = 1'b0;
    nchk++; if (dataOut !== 40'h0) begin nerr++; $display("FAIL rstld_data got %h exp 0", dataOut); end
    nchk++; if (count !== 3'd0) begin nerr++; $display("FAIL rstld_count got %0d exp 0", count); end
    nchk++; if (validVec !== 5'b0) begin nerr++; $display("FAIL rstld_valid got %b exp 0", validVec); end
  endtask

  task automatic test_sweep_d2();
    tick();
    nchk++; if (cnt1 !== 2'd0) begin nerr++; $display("FAIL d2_rst_count got %0d exp 0", cnt1); end
    rst1 = 1'b1; sh1 = 1'b1; din1 = 1'b1;
    tick();
    nchk++; if (cnt1 !== 2'd1 || full1 !== 1'b0) begin nerr++; $display("FAIL d2_one count %0d full %b exp 1 0", cnt1, full1); end
    din1 = 1'b0;
    tick();
    nchk++; if (dout1 !== 2'b10) begin nerr++; $display("FAIL d2_fill_data got %b exp 10", dout1); end
    nchk++; if (cnt1 !== 2'd2 || full1 !== 1'b1) begin nerr++; $display("FAIL d2_fill count %0d full %b exp 2 1", cnt1, full1); end
    nchk++; if (tail1 !== 1'b1 || drop1 !== 1'b0) begin nerr++; $display("FAIL d2_fill tail %b drop %b exp 1 0", tail1, drop1); end
    din1 = 1'b1;
    tick();
    sh1 = 1'b0;
    nchk++; if (dout1 !== 2'b01 || tail1 !== 1'b0) begin nerr++; $display("FAIL d2_ovf data %b tail %b exp 01 0", dout1, tail1); end
    nchk++; if (drop1 !== 1'b1 || cnt1 !== 2'd2) begin nerr++; $display("FAIL d2_ovf drop %b count %0d exp 1 2", drop1, cnt1); end
    tick();
    nchk++; if (drop1 !== 1'b0) begin nerr++; $display("FAIL d2_drop_end got %b exp 0", drop1); end
    nchk++; if ($isunknown({dout1, tail1, vv1, cnt1, full1, drop1})) begin nerr++; $display("FAIL d2_xcheck got %b exp no X", {dout1, tail1, vv1, cnt1, full1, drop1}); end
  endtask

  task automatic test_sweep_d9();
    tick();
    nchk++; if (cnt2 !== 4'd0) begin nerr++; $display("FAIL d9_rst_count got %0d exp 0", cnt2); end
    rst2 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sh2 = 1'b1; din2 = 16'h1001 + 16'(i);
      tick();
      nchk++; if (cnt2 !== 4'(i + 1) || full2 !== (i == 8)) begin nerr++; $display("FAIL d9_fill%0d count %0d full %b exp %0d %b", i, cnt2, full2, i + 1, i == 8); end
    end
    nchk++; if (tail2 !== 16'h1001 || dout2[15:0] !== 16'h1009) begin nerr++; $display("FAIL d9_fill tail %h head %h exp 1001 1009", tail2, dout2[15:0]); end
    din2 = 16'hBEEF;
    tick();
    sh2 = 1'b0;
    nchk++; if (tail2 !== 16'h1002 || dout2[15:0] !== 16'hBEEF) begin nerr++; $display("FAIL d9_ovf tail %h head %h exp 1002 beef", tail2, dout2[15:0]); end
    nchk++; if (drop2 !== 1'b1 || cnt2 !== 4'd9 || full2 !== 1'b1) begin nerr++; $display("FAIL d9_ovf drop %b count %0d full %b exp 1 9 1", drop2, cnt2, full2); end
    tick();
    nchk++; if (drop2 !== 1'b0) begin nerr++; $display("FAIL d9_drop_end got %b exp 0", drop2); end
    nchk++; if ($isunknown({dout2, tail2, vv2, cnt2, full2, drop2})) begin nerr++; $display("FAIL d9_xcheck got X on outputs exp none"); end
  endtask

  initial begin
    test_reset();
    test_shift_fill();
    test_overflow();
    test_indexed_load();
    test_simultaneous();
    test_sweep_d2();
    test_sweep_d9();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
